// File: rtl/fir_mac_sequencer_if.sv
// Handshake and status bundle between the FIR MAC sequencer (master) and its FIFOs/datapath (slave).
interface fir_mac_sequencer_if #(
   parameter int unsigned TAP_NUMBER = 20,
   parameter int unsigned CNT_WIDTH  = 32
);
   localparam int unsigned TAP_W = $clog2(TAP_NUMBER);

   logic                 enable;
   logic                 in_empty;
   logic                 in_rd_en;
   logic                 shift_en;
   logic [TAP_W-1:0]     tap_idx;
   logic                 mac_issue;
   logic                 acc_clr;
   logic                 out_full;
   logic                 out_wr_en;
   logic                 busy;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] frame_cnt;

   modport master (
      input  enable, in_empty, out_full,
      output in_rd_en, shift_en, tap_idx, mac_issue, acc_clr, out_wr_en, busy,
             stall_cnt, frame_cnt
   );

   modport slave (
      output enable, in_empty, out_full,
      input  in_rd_en, shift_en, tap_idx, mac_issue, acc_clr, out_wr_en, busy,
             stall_cnt, frame_cnt
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a shared FIR MAC datapath: read/decimate, issue taps, drain, write.
// Optional statistics counters are built only when FIR_SEQ_STATS_EN is defined.
module fir_mac_sequencer #(
   parameter int unsigned TAP_NUMBER  = 20,
   parameter int unsigned DECIMATION  = 1,
   parameter int unsigned MAC_LATENCY = 2,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input logic                  clock,
   input logic                  reset,
   fir_mac_sequencer_if.master  bus
);
   localparam int unsigned TAP_W = $clog2(TAP_NUMBER);
   localparam int unsigned DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam int unsigned LAT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_NUMBER - 1);
   localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATION - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAC_LATENCY - 1);

   typedef enum logic [1:0] {StRead, StIssue, StDrain, StWrite} state_e;

   state_e             state_q, state_d;
   logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
   logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

   logic               rd;
   logic               issue;
   logic               clr;
   logic               wr;
   logic [TAP_W-1:0]   tap_out;

   always_comb begin
      state_d   = state_q;
      dec_cnt_d = dec_cnt_q;
      tap_cnt_d = tap_cnt_q;
      lat_cnt_d = lat_cnt_q;
      rd        = 1'b0;
      issue     = 1'b0;
      clr       = 1'b0;
      wr        = 1'b0;
      tap_out   = '0;
      unique case (state_q)
         StRead: begin
            if (bus.enable && !bus.in_empty) begin
               rd = 1'b1;
               if (dec_cnt_q == DEC_LAST) begin
                  dec_cnt_d = '0;
                  tap_cnt_d = '0;
                  state_d   = StIssue;
               end else begin
                  dec_cnt_d = dec_cnt_q + DEC_W'(1);
               end
            end
         end
         StIssue: begin
            issue   = 1'b1;
            tap_out = tap_cnt_q;
            clr     = (tap_cnt_q == '0);
            if (tap_cnt_q == TAP_LAST) begin
               tap_cnt_d = '0;
               lat_cnt_d = '0;
               state_d   = StDrain;
            end else begin
               tap_cnt_d = tap_cnt_q + TAP_W'(1);
            end
         end
         StDrain: begin
            if (lat_cnt_q == LAT_LAST) begin
               lat_cnt_d = '0;
               state_d   = StWrite;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         StWrite: begin
            if (!bus.out_full) begin
               wr      = 1'b1;
               state_d = StRead;
            end
         end
         default: state_d = StRead;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StRead;
         dec_cnt_q <= '0;
         tap_cnt_q <= '0;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         dec_cnt_q <= dec_cnt_d;
         tap_cnt_q <= tap_cnt_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   // Outputs are forced low while reset is held, not just after the clock edge.
   assign bus.in_rd_en  = rd & ~reset;
   assign bus.shift_en  = rd & ~reset;
   assign bus.mac_issue = issue & ~reset;
   assign bus.acc_clr   = clr & ~reset;
   assign bus.out_wr_en = wr & ~reset;
   assign bus.tap_idx   = reset ? '0 : tap_out;
   assign bus.busy      = (state_q != StRead) & ~reset;

`ifdef FIR_SEQ_STATS_EN
   logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (wr && (frame_cnt_q != '1)) begin
         frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      end
      if ((state_q == StWrite) && bus.out_full && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.frame_cnt = reset ? '0 : frame_cnt_q;
   assign bus.stall_cnt = reset ? '0 : stall_cnt_q;
`else
   assign bus.frame_cnt = {CNT_WIDTH{1'b0}};
   assign bus.stall_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Randomised self-checking bench for fir_mac_sequencer against a frame-position reference model.
module tb_fir_mac_sequencer;
   localparam int unsigned TAP    = 20;
   localparam int unsigned DEC    = 3;
   localparam int unsigned LAT    = 2;
   localparam int unsigned CW     = 4;
   localparam int          WR_POS = TAP + LAT + 1;
   localparam int          CMAX   = (1 << CW) - 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fir_mac_sequencer_if #(.TAP_NUMBER(TAP), .CNT_WIDTH(CW)) bus ();

   fir_mac_sequencer #(
      .TAP_NUMBER (TAP),
      .DECIMATION (DEC),
      .MAC_LATENCY(LAT),
      .CNT_WIDTH  (CW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: m_pos 0 = waiting for samples, 1..TAP = issuing tap m_pos-1,
   // then drain, and WR_POS = waiting to write.
   int m_pos    = 0;
   int m_group  = 0;
   int m_frames = 0;
   int m_stalls = 0;
   int cyc      = 0;
   int t_rd     = 0;
   bit stalled  = 1'b0;
   int n_rd     = 0;
   int n_wr     = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_cycle();
      bit e_rd, e_iss, e_clr, e_wr, e_busy;
      int e_tap, e_frame, e_stall;
      e_rd = 0; e_iss = 0; e_clr = 0; e_wr = 0; e_busy = 0;
      e_tap = 0; e_frame = 0; e_stall = 0;
      if (reset) begin
         m_pos = 0; m_group = 0; m_frames = 0; m_stalls = 0;
      end else begin
         e_busy = (m_pos != 0);
`ifdef FIR_SEQ_STATS_EN
         e_frame = m_frames;
         e_stall = m_stalls;
`endif
         if (m_pos == 0) begin
            if (bus.enable && !bus.in_empty) begin
               e_rd = 1;
               m_group++;
               if (m_group == DEC) begin
                  m_group = 0;
                  m_pos   = 1;
                  stalled = 0;
                  t_rd    = cyc;
               end
            end
         end else if (m_pos <= TAP) begin
            e_iss = 1;
            e_tap = m_pos - 1;
            e_clr = (m_pos == 1);
            m_pos++;
         end else if (m_pos < WR_POS) begin
            m_pos++;
         end else if (!bus.out_full) begin
            e_wr  = 1;
            m_pos = 0;
            if (!stalled && bus.out_wr_en) check_val("latency", 64'(cyc - t_rd), 64'(WR_POS));
            if (m_frames < CMAX) m_frames++;
         end else begin
            stalled = 1;
            if (m_stalls < CMAX) m_stalls++;
         end
      end
      check_val("in_rd_en", bus.in_rd_en, e_rd);
      check_val("shift_en", bus.shift_en, e_rd);
      check_val("mac_issue", bus.mac_issue, e_iss);
      check_val("acc_clr", bus.acc_clr, e_clr);
      check_val("tap_idx", 64'(bus.tap_idx), 64'(e_tap));
      check_val("out_wr_en", bus.out_wr_en, e_wr);
      check_val("busy", bus.busy, e_busy);
      check_val("frame_cnt", 64'(bus.frame_cnt), 64'(e_frame));
      check_val("stall_cnt", 64'(bus.stall_cnt), 64'(e_stall));
      check_val("rd_when_empty", bus.in_rd_en & bus.in_empty, 0);
      check_val("wr_when_full", bus.out_wr_en & bus.out_full, 0);
      check_val("rd_and_wr", bus.in_rd_en & bus.out_wr_en, 0);
      n_rd += int'(bus.in_rd_en);
      n_wr += int'(bus.out_wr_en);
      cyc++;
   endtask

   task automatic drive(input bit en, input bit emp, input bit full, input bit rst);
      bus.enable   = en;
      bus.in_empty = emp;
      bus.out_full = full;
      reset        = rst;
      @(negedge clock);
      model_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      repeat (3) drive(0, 1, 0, 1);

      // Single frame, no backpressure; data then FIFO empty.
      repeat (DEC) drive(1, 0, 0, 0);
      repeat (40) drive(1, 1, 0, 0);

      // Output FIFO full for 5 cycles once WRITE is reached.
      repeat (DEC) drive(1, 0, 0, 0);
      repeat (TAP + LAT) drive(0, 1, 0, 0);
      repeat (5) drive(0, 1, 1, 0);
      drive(0, 1, 0, 0);
`ifdef FIR_SEQ_STATS_EN
      check_val("stall_after_bp", 64'(bus.stall_cnt), 64'(5));
      check_val("frames_after_bp", 64'(bus.frame_cnt), 64'(2));
`else
      check_val("stall_after_bp", 64'(bus.stall_cnt), 64'(0));
      check_val("frames_after_bp", 64'(bus.frame_cnt), 64'(0));
`endif
      repeat (3) drive(0, 1, 0, 0);

      // Empty toggling every cycle; data keeps arriving during ISSUE/DRAIN/WRITE.
      for (int i = 0; i < 80; i++) drive(1, i[0], 0, 0);

      // Reset while issuing tap 7.
      for (int i = 0; i < 200 && m_pos != 8; i++) drive(1, 0, 0, 0);
      check_val("reach_tap7", 64'(m_pos), 64'(8));
      drive(1, 0, 0, 1);
      check_val("after_rst_busy", bus.busy, 0);
      for (int i = 0; i < 60; i++) drive(1, 0, 0, 0);

      // Enable drops while issuing tap 3, with samples waiting.
      for (int i = 0; i < 200 && m_pos != 4; i++) drive(1, 0, 0, 0);
      check_val("reach_tap3", 64'(m_pos), 64'(4));
      n_rd = 0;
      n_wr = 0;
      repeat (60) drive(0, 0, 0, 0);
      check_val("en_drop_writes", 64'(n_wr), 64'(1));
      check_val("en_drop_reads", 64'(n_rd), 64'(0));

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
